// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the AES round steps, using rising-edge handshakes and a per-step watchdog
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sub_done,
  input  logic       shift_done,
  input  logic       mix_done,
  input  logic       ark_done,
  output logic       load_en,
  output logic       sub_en,
  output logic       shift_en,
  output logic       mix_en,
  output logic       ark_en,
  output logic [3:0] round_o,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [3:0] {IDLE, LOAD, ARK0, SUB, SHIFT, MIX, ARK, FIN, ERR} state_e;
  state_e state_q, state_d;
  logic [3:0] dn, dn_q, round_d;
  logic [7:0] wd_q, wd_d;
  logic [1:0] idx;
  logic step, first, last, fire, expire, entry;
  logic load_en_d, sub_en_d, shift_en_d, mix_en_d, ark_en_d, busy_d, done_d, error_d;
  assign dn     = {sub_done, shift_done, mix_done, ark_done};
  assign step   = state_q inside {ARK0, SUB, SHIFT, MIX, ARK};
  assign first  = sub_en | shift_en | mix_en | ark_en;
  assign last   = round_o == 4'(NR);
  assign idx    = state_q == SUB ? 2'd3 : state_q == SHIFT ? 2'd2 : state_q == MIX ? 2'd1 : 2'd0;
  // the enable cycle itself never completes a step; only a fresh rise afterwards does
  assign fire   = step && !first && dn[idx] && !dn_q[idx];
  assign expire = step && !fire && wd_q == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR: if (start) state_d = LOAD;
      LOAD:      state_d = ARK0;
      ARK0:      if (fire) state_d = SUB;
      SUB:       if (fire) state_d = SHIFT;
      SHIFT:     if (fire) state_d = last ? ARK : MIX;
      MIX:       if (fire) state_d = ARK;
      ARK:       if (fire) state_d = last ? FIN : SUB;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (expire) state_d = ERR;
  end
  always_comb begin
    entry      = state_d != state_q;
    round_d    = state_d == LOAD ? 4'd0 :
                 state_q == ARK0 && fire ? 4'd1 :
                 state_q == ARK && fire && !last ? round_o + 4'd1 : round_o;
    wd_d       = entry ? 8'd0 : step ? wd_q + 8'd1 : wd_q;
    load_en_d  = state_d == LOAD;
    sub_en_d   = entry && state_d == SUB;
    shift_en_d = entry && state_d == SHIFT;
    mix_en_d   = entry && state_d == MIX;
    ark_en_d   = entry && (state_d == ARK0 || state_d == ARK);
    busy_d     = state_d inside {LOAD, ARK0, SUB, SHIFT, MIX, ARK};
    done_d     = state_d == FIN;
    error_d    = state_d == ERR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {load_en, sub_en, shift_en, mix_en, ark_en, busy, done, error} <= '0;
      round_o <= '0;
      wd_q    <= '0;
      dn_q    <= '0;
    end else begin
      {load_en, sub_en, shift_en, mix_en, ark_en} <= {load_en_d, sub_en_d, shift_en_d, mix_en_d, ark_en_d};
      {busy, done, error} <= {busy_d, done_d, error_d};
      round_o <= round_d;
      wd_q    <= wd_d;
      dn_q    <= dn;
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: emulates the step units with random latencies and checks against an event-sequence model
module tb_aes_round_ctrl;
  logic clk = 0, rst = 0;
  logic [1:0] start = '0, sub_done = '0, shift_done = '0, mix_done = '0, ark_done = '0;
  logic [1:0] load_en, sub_en, shift_en, mix_en, ark_en, busy, done, error;
  logic [3:0] round_o [2];
  int errors = 0, checks = 0;
  logic [7:0] obs[$], exp_q[$];
  int fin_cyc, err_cyc, mix1_cyc, exp_fin;
  bit busy_bad, rst_hit;
  logic [11:0] rst_snap;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10), .TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .sub_done(sub_done[0]), .shift_done(shift_done[0]), .mix_done(mix_done[0]), .ark_done(ark_done[0]),
    .load_en(load_en[0]), .sub_en(sub_en[0]), .shift_en(shift_en[0]), .mix_en(mix_en[0]), .ark_en(ark_en[0]),
    .round_o(round_o[0]), .busy(busy[0]), .done(done[0]), .error(error[0]));

  aes_round_ctrl #(.NR(1), .TIMEOUT(255)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .sub_done(sub_done[1]), .shift_done(shift_done[1]), .mix_done(mix_done[1]), .ark_done(ark_done[1]),
    .load_en(load_en[1]), .sub_en(sub_en[1]), .shift_en(shift_en[1]), .mix_en(mix_en[1]), .ark_en(ark_en[1]),
    .round_o(round_o[1]), .busy(busy[1]), .done(done[1]), .error(error[1]));

  function automatic logic [11:0] outs(input int d);
    return {load_en[d], sub_en[d], shift_en[d], mix_en[d], ark_en[d], busy[d], done[d], error[d], round_o[d]};
  endfunction

  // event codes: 1 load, 2 ark, 3 sub, 4 shift, 5 mix, 6 done; low nibble is round_o
  function automatic void build_exp(input int nr);
    exp_q.delete();
    exp_q.push_back({4'd1, 4'd0});
    exp_q.push_back({4'd2, 4'd0});
    for (int r = 1; r <= nr; r++) begin
      exp_q.push_back({4'd3, 4'(r)});
      exp_q.push_back({4'd4, 4'(r)});
      if (r < nr) exp_q.push_back({4'd5, 4'(r)});
      exp_q.push_back({4'd2, 4'(r)});
    end
    exp_q.push_back({4'd6, 4'(nr)});
  endfunction

  function automatic bit seq_ok(input int n);
    if (obs.size() != n) return 0;
    for (int i = 0; i < n; i++) if (obs[i] !== exp_q[i]) return 0;
    return 1;
  endfunction

  // mode: 0 normal, 1 extra start at round 4, 2 ark_done held into round-2 ARK, 3 mix_done stuck low, 4 rst in round-6 SHIFT
  task automatic run(input int d, input int lat, input int mode);
    int fire[4];
    int l, hold_end;
    bit hold;
    logic [3:0] en, r;
    obs.delete();
    fin_cyc = -1; err_cyc = -1; mix1_cyc = -1; exp_fin = 2; busy_bad = 0; rst_hit = 0;
    hold = 0; hold_end = -1;
    fire = '{-1, -1, -1, -1};
    @(negedge clk);
    start[d] = 1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start[d] = 0;
      en = {sub_en[d], shift_en[d], mix_en[d], ark_en[d]};
      r = round_o[d];
      if (load_en[d]) obs.push_back({4'd1, r});
      if (ark_en[d]) obs.push_back({4'd2, r});
      if (sub_en[d]) obs.push_back({4'd3, r});
      if (shift_en[d]) obs.push_back({4'd4, r});
      if (mix_en[d]) obs.push_back({4'd5, r});
      if (done[d]) obs.push_back({4'd6, r});
      if (busy[d] !== !(done[d] || error[d])) busy_bad = 1;
      if (error[d] && en != 0) busy_bad = 1;
      if (mix_en[d] && r == 1 && mix1_cyc < 0) mix1_cyc = c;
      if (done[d]) begin fin_cyc = c; break; end
      if (error[d]) begin err_cyc = c; break; end
      if (mode == 4 && shift_en[d] && r == 6) begin
        rst = 1;
        #1 rst_snap = outs(d);
        rst_hit = 1;
        #1 rst = 0;
        break;
      end
      if (mode == 1 && sub_en[d] && r == 4) start[d] = 1;
      if (mode == 2 && mix_en[d] && r == 2) hold = 1;
      for (int u = 0; u < 4; u++) if (en[u]) begin
        l = lat > 0 ? lat : int'($urandom_range(1, 5));
        if (mode == 2 && u == 0 && r == 2 && hold) begin l = 6; hold_end = c + 4; end
        fire[u] = c + l;
        exp_fin += l + 1;
      end
      if (hold_end >= 0 && c > hold_end) hold = 0;
      sub_done[d]   = c == fire[3];
      shift_done[d] = c == fire[2];
      mix_done[d]   = mode != 3 && c == fire[1];
      ark_done[d]   = hold || c == fire[0];
    end
    {sub_done[d], shift_done[d], mix_done[d], ark_done[d], start[d]} = '0;
  endtask

  task automatic test_reset();
    bit moved = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== 12'h0) begin errors++; $display("FAIL reset_outs[%0d]: got %h want 000", d, outs(d)); end
    end
    rst = 0;
    repeat (6) begin
      @(negedge clk);
      if (outs(0) !== 12'h0 || outs(1) !== 12'h0) moved = 1;
    end
    checks++;
    if (moved) begin errors++; $display("FAIL idle_quiet: got outputs moving want all 0"); end
  endtask

  task automatic check_full(input int d, input int nr, input int want_fin, input string tag);
    build_exp(nr);
    checks++;
    if (!seq_ok(exp_q.size())) begin errors++; $display("FAIL %s_seq: got %0d events want %0d in order", tag, obs.size(), exp_q.size()); end
    checks++;
    if (fin_cyc != want_fin) begin errors++; $display("FAIL %s_latency: got %0d want %0d", tag, fin_cyc, want_fin); end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL %s_busy: got bad busy/enable profile want clean", tag); end
    @(negedge clk);
    checks++;
    if ({done[d], busy[d], round_o[d]} !== {2'b00, 4'(nr)}) begin
      errors++; $display("FAIL %s_after: got done=%b busy=%b round=%0d want 0 0 %0d", tag, done[d], busy[d], round_o[d], nr);
    end
  endtask

  task automatic test_full();
    run(0, 2, 0);
    check_full(0, 10, 2 + 4 * 10 * 3, "full");
  endtask

  task automatic test_start_ignored();
    run(0, 2, 1);
    check_full(0, 10, 122, "start_ign");
  endtask

  task automatic test_random_latency();
    for (int i = 0; i < 3; i++) begin
      run(0, 0, 0);
      check_full(0, 10, exp_fin, "rand_lat");
    end
  endtask

  task automatic test_timeout();
    bit held = 1;
    run(0, 2, 3);
    build_exp(10);
    checks++;
    if (!seq_ok(5)) begin errors++; $display("FAIL to_seq: got %0d events want 5 in order", obs.size()); end
    checks++;
    if (mix1_cyc < 0 || err_cyc - mix1_cyc != 255) begin
      errors++; $display("FAIL to_delay: got %0d want 255 (mix_en@%0d err@%0d)", err_cyc - mix1_cyc, mix1_cyc, err_cyc);
    end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL to_busy: got busy/enable high with error want 0"); end
    repeat (4) begin
      @(negedge clk);
      if (outs(0) !== {8'b0000_0001, 4'd1}) held = 0;
    end
    checks++;
    if (!held) begin errors++; $display("FAIL to_hold: got %h want 011", outs(0)); end
    run(0, 2, 0);
    check_full(0, 10, 122, "to_restart");
  endtask

  task automatic test_reset_mid();
    bit moved = 0;
    run(0, 2, 4);
    checks++;
    if (!rst_hit || rst_snap !== 12'h0) begin errors++; $display("FAIL mid_rst: got hit=%0d outs=%h want 1 000", rst_hit, rst_snap); end
    repeat (5) begin
      @(negedge clk);
      if (outs(0) !== 12'h0) moved = 1;
    end
    checks++;
    if (moved) begin errors++; $display("FAIL mid_quiet: got outputs moving want all 0"); end
    run(0, 0, 0);
    check_full(0, 10, exp_fin, "mid_restart");
  endtask

  task automatic test_ark_hold();
    run(0, 2, 2);
    check_full(0, 10, 122 + 4, "ark_hold");
  endtask

  task automatic test_nr1();
    run(1, 2, 0);
    check_full(1, 1, 2 + 4 * 3, "nr1");
    run(1, 0, 0);
    check_full(1, 1, exp_fin, "nr1_rand");
  endtask

  initial begin
    #2;
    test_reset();
    test_full();
    test_start_ignored();
    test_random_latency();
    test_timeout();
    test_reset_mid();
    test_ark_hold();
    test_nr1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of cipher rounds (legal 1..14).
REQ-002 Parameter: TIMEOUT, default 255, maximum cycles to wait for one step to complete (legal 1..255).
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  reset; asynchronous, active-high.
REQ-005 Port: start  in  1  request to encrypt the loaded block.
REQ-006 Port: sub_done, shift_done, mix_done, ark_done  in  1 each  step-complete levels from the SubBytes, ShiftRows, MixColumns and AddRoundKey units.
REQ-007 Port: load_en  out  1  one-cycle pulse that loads plaintext into the state register.
REQ-008 Port: sub_en, shift_en, mix_en, ark_en  out  1 each  one-cycle step-start pulses.
REQ-009 Port: round_o  out  4  current round number; also serves as the round-key index.
REQ-010 Port: busy  out  1  high while a block is in progress.
REQ-011 Port: done  out  1  one-cycle pulse when the block is complete.
REQ-012 Port: error  out  1  sticky step-timeout flag.

Function
REQ-013 FSM states: IDLE, LOAD, ARK0, SUB, SHIFT, MIX, ARK, FIN, ERR; all outputs registered.
REQ-014 IDLE or ERR with start=1: go to LOAD; clear error; set round_o=0; set busy=1 on the same edge.
REQ-015 start is ignored while busy=1 and in FIN.
REQ-016 LOAD: load_en=1 for exactly one cycle, then go to ARK0.
REQ-017 Step state (ARK0, SUB, SHIFT, MIX, ARK) entry: the matching *_en is high only in the first cycle of the state.
REQ-018 Completion: a step completes on the first cycle after its enable pulse where its done input is 1 and its registered value from the previous cycle was 0 (rising edge). A done input already held high from an earlier step does not count.
REQ-019 ARK0 complete: round_o <= 1, go to SUB.
REQ-020 SUB complete: go to SHIFT.
REQ-021 SHIFT complete: go to MIX if round_o < NR; otherwise go to ARK. MixColumns is skipped in the final round.
REQ-022 MIX complete: go to ARK.
REQ-023 ARK complete with round_o < NR: round_o <= round_o+1, go to SUB.
REQ-024 ARK complete with round_o == NR: go to FIN.
REQ-025 FIN: done=1 for one cycle, busy=0, round_o holds NR, then go to IDLE.
REQ-026 Watchdog: an 8-bit counter clears on every step-state entry and increments each cycle the step is incomplete.
REQ-027 Watchdog expiry: when the counter reaches TIMEOUT, go to ERR with error=1, busy=0, no enables. ERR holds until start or rst.
REQ-028 Timeout and completion in the same cycle: completion wins.
REQ-029 Total latency with 1-cycle-responding units is deterministic: 1 (LOAD) + per-step cycles + 1 (FIN).
REQ-030 Any done input rising outside its own step state is ignored.

Reset
REQ-031 rst=1 immediately forces state=IDLE, round_o=0, watchdog=0, and busy, done, error, load_en and all *_en to 0, including when asserted mid-round.
REQ-032 After rst deassertion, no output toggles until start=1 is sampled.

Verification
REQ-033 NR=10, each done rises 2 cycles after its enable: start -> load_en, then ark_en x11, sub_en x10, shift_en x10, mix_en x9; mix_en absent in round 10; done pulses once with round_o=10.
REQ-034 Same setup, start pulsed at round_o=4 -> ignored; sequence and cycle count identical to REQ-033.
REQ-035 mix_done held low, TIMEOUT=255 -> error=1 and busy=0 exactly 255 cycles after mix_en in round 1; a following start clears error and restarts from round_o=0.
REQ-036 rst pulsed during SHIFT of round 6 -> all outputs 0 asynchronously; a subsequent start runs a full clean sequence.
REQ-037 ark_done kept high from the prior step into the next ARK -> no advance until ark_done falls and rises again.
REQ-038 NR=1 -> sequence LOAD, ARK0, SUB, SHIFT, ARK, FIN with no mix_en; done asserted.
